// File: rtl/cnn_wgt_pkg.sv
// Shared types and helpers for the CNN ping-pong weight buffer.
// The optional zero-row flag output of wgt_buf_pp is enabled by defining WGT_ZERO_ROW_EN.
package cnn_wgt_pkg;

    localparam int unsigned DEF_DW   = 8;
    localparam int unsigned DEF_K    = 5;
    localparam int unsigned DEF_ROWS = 5;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_FULL  = 2'd2
    } shd_state_e;

    // Bit offset of weight [r][k] in a flat kernel bus.
    function automatic int unsigned wgt_off(input int unsigned r, input int unsigned k,
                                            input int unsigned kk, input int unsigned dw);
        return (r * kk + k) * dw;
    endfunction

endpackage

// File: rtl/wgt_bank.sv
// N x DW weight register array: indexed single-word write, full parallel load, flat read bus.
module wgt_bank #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 25,
    parameter int unsigned CW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en_i,
    input  logic [CW-1:0]   wr_idx_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic            ld_en_i,
    input  logic [N*DW-1:0] ld_data_i,
    output logic [N*DW-1:0] rd_data_o
);

    logic [N*DW-1:0] bank_q;

    // Parallel load takes precedence over the single-word write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (ld_en_i) begin
            bank_q <= ld_data_i;
        end else if (wr_en_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_idx_i == CW'(i)) begin
                    bank_q[i*DW +: DW] <= wr_data_i;
                end
            end
        end
    end

    assign rd_data_o = bank_q;

endmodule

// File: rtl/wgt_buf_pp.sv
// Ping-pong weight buffer: shadow bank loads serially while the active bank feeds the PE array.
// Define WGT_ZERO_ROW_EN to add the registered per-row all-zero flags (row_zero).
module wgt_buf_pp
    import cnn_wgt_pkg::*;
#(
    parameter int unsigned DW   = DEF_DW,
    parameter int unsigned K    = DEF_K,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        wgt_in,
    input  logic                 wgt_valid,
    output logic                 wgt_ready,
    input  logic                 flush,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 shadow_full,
    output logic                 act_valid,
    output logic [ROWS*K*DW-1:0] act_wgt
`ifdef WGT_ZERO_ROW_EN
    ,
    output logic [ROWS-1:0]      row_zero
`endif
);

    localparam int unsigned N  = ROWS * K;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    shd_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wgt_ready_q, wgt_ready_d;
    logic          shadow_full_q, shadow_full_d;
    logic          swap_ack_q, swap_ack_d;
    logic          act_valid_q, act_valid_d;
    logic          accept, swap_fire;
    logic [N*DW-1:0] shd_data;

    assign accept    = wgt_valid && wgt_ready_q;
    assign swap_fire = swap_req && (state_q == S_FULL);

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_EMPTY;
            cnt_q         <= '0;
            wgt_ready_q   <= 1'b1;
            shadow_full_q <= 1'b0;
            swap_ack_q    <= 1'b0;
            act_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wgt_ready_q   <= wgt_ready_d;
            shadow_full_q <= shadow_full_d;
            swap_ack_q    <= swap_ack_d;
            act_valid_q   <= act_valid_d;
        end
    end

    // Next state: swap beats flush, flush beats accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (swap_fire || flush) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            if (cnt_q == CW'(N - 1)) begin
                state_d = S_FULL;
                cnt_d   = '0;
            end else begin
                state_d = S_LOAD;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        wgt_ready_d   = (state_d != S_FULL);
        shadow_full_d = (state_d == S_FULL);
        swap_ack_d    = swap_fire;
        act_valid_d   = act_valid_q || swap_fire;
    end

    wgt_bank #(.DW(DW), .N(N), .CW(CW)) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept && !flush),
        .wr_idx_i  (cnt_q),
        .wr_data_i (wgt_in),
        .ld_en_i   (1'b0),
        .ld_data_i ('0),
        .rd_data_o (shd_data)
    );

    wgt_bank #(.DW(DW), .N(N), .CW(CW)) u_active (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (1'b0),
        .wr_idx_i  ('0),
        .wr_data_i ('0),
        .ld_en_i   (swap_fire),
        .ld_data_i (shd_data),
        .rd_data_o (act_wgt)
    );

    assign wgt_ready   = wgt_ready_q;
    assign shadow_full = shadow_full_q;
    assign swap_ack    = swap_ack_q;
    assign act_valid   = act_valid_q;

`ifdef WGT_ZERO_ROW_EN
    logic [ROWS-1:0] row_zero_q, row_zero_d;

    // Flags computed from the incoming shadow kernel so they land with act_wgt.
    always_comb begin
        row_zero_d = '1;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned k = 0; k < K; k++) begin
                if (shd_data[wgt_off(r, k, K, DW) +: DW] != '0) begin
                    row_zero_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_zero_q <= '1;
        end else if (swap_fire) begin
            row_zero_q <= row_zero_d;
        end
    end

    assign row_zero = row_zero_q;
`endif

endmodule

// File: tb/tb_wgt_buf_pp.sv
// Directed scoreboard bench for wgt_buf_pp at default parameters.
module tb_wgt_buf_pp;

    localparam int unsigned DW   = 8;
    localparam int unsigned K    = 5;
    localparam int unsigned ROWS = 5;
    localparam int unsigned N    = ROWS * K;
    localparam int unsigned W    = N * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wgt_in;
    logic          wgt_valid;
    logic          wgt_ready;
    logic          flush;
    logic          swap_req;
    logic          swap_ack;
    logic          shadow_full;
    logic          act_valid;
    logic [W-1:0]  act_wgt;
`ifdef WGT_ZERO_ROW_EN
    logic [ROWS-1:0] row_zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];
    logic [W-1:0] k_a, k_7, k_3, k_cur, k_exp;

    always #5 clk = ~clk;

    wgt_buf_pp #(.DW(DW), .K(K), .ROWS(ROWS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wgt_in      (wgt_in),
        .wgt_valid   (wgt_valid),
        .wgt_ready   (wgt_ready),
        .flush       (flush),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .shadow_full (shadow_full),
        .act_valid   (act_valid),
        .act_wgt     (act_wgt)
`ifdef WGT_ZERO_ROW_EN
        ,
        .row_zero    (row_zero)
`endif
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] fill(input int v);
        logic [W-1:0] t;
        for (int i = 0; i < N; i++) t[i*DW +: DW] = DW'(v);
        return t;
    endfunction

    // Waits (bounded) for swap_ack with swap_req already asserted; compares against scoreboard.
    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!swap_ack && n < 8);
        chk("ack_seen", W'(swap_ack), W'(1));
        if (swap_ack) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", W'(1), W'(0));
            end else begin
                k_exp = sb_q.pop_front();
                chk("act_wgt_swap", act_wgt, k_exp);
                chk("act_valid_swap", W'(act_valid), W'(1));
            end
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < N; i++) k_a[i*DW +: DW] = DW'(i - 12);
        k_7 = fill(7);
        k_3 = fill(3);

        rst_n = 1'b0; wgt_in = '0; wgt_valid = 1'b0; flush = 1'b0; swap_req = 1'b0;
        repeat (3) step();
        chk("rst_ready", W'(wgt_ready), W'(1));
        chk("rst_full", W'(shadow_full), W'(0));
        chk("rst_ack", W'(swap_ack), W'(0));
        chk("rst_act_valid", W'(act_valid), W'(0));
        chk("rst_act_wgt", act_wgt, W'(0));
`ifdef WGT_ZERO_ROW_EN
        chk("rst_row_zero", W'(row_zero), W'({ROWS{1'b1}}));
`endif
        rst_n = 1'b1;
        step();

        // Kernel A: -12..12 with valid held high.
        wgt_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            wgt_in = DW'(i - 12);
            chk("ready_load_a", W'(wgt_ready), W'(1));
            chk("full_early_a", W'(shadow_full), W'(0));
            step();
        end
        wgt_valid = 1'b0;
        chk("full_a", W'(shadow_full), W'(1));
        chk("ready_full_a", W'(wgt_ready), W'(0));
        chk("act_valid_pre", W'(act_valid), W'(0));
        chk("elem0_a", W'(k_a[DW-1:0]), W'(8'hF4));
        sb_q.push_back(k_a);

        swap_req = 1'b1;
        wait_ack(n);
        swap_req = 1'b0;
        chk("swap_lat_a", W'(n), W'(1));
        chk("ready_post_swap", W'(wgt_ready), W'(1));
        chk("full_post_swap", W'(shadow_full), W'(0));
        step();
        chk("ack_one_cycle", W'(swap_ack), W'(0));

        // Overlap: 7s at 1/3 duty with swap_req held early.
        swap_req = 1'b1;
        for (int i = 0; i < 73; i++) begin
            wgt_valid = (i % 3 == 0);
            wgt_in = DW'(7);
            step();
            chk("no_ack_loading", W'(swap_ack), W'(0));
            chk("act_stable_ovl", act_wgt, k_a);
        end
        wgt_valid = 1'b0;
        chk("full_7", W'(shadow_full), W'(1));
        sb_q.push_back(k_7);
        wait_ack(n);
        swap_req = 1'b0;
        chk("swap_lat_7", W'(n), W'(1));

        // Flush mid-load (flush beats a same-cycle accept), then 3s with coincident final swap_req.
        wgt_valid = 1'b1;
        wgt_in = DW'(9);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("full_after_flush", W'(shadow_full), W'(0));
        wgt_in = DW'(3);
        for (int i = 0; i < N - 1; i++) begin
            step();
            chk("full_early_3", W'(shadow_full), W'(0));
        end
        swap_req = 1'b1;
        step();
        wgt_valid = 1'b0;
        chk("coinc_no_ack", W'(swap_ack), W'(0));
        chk("coinc_full", W'(shadow_full), W'(1));
        chk("coinc_act_7", act_wgt, k_7);
        sb_q.push_back(k_3);
        wait_ack(n);
        swap_req = 1'b0;
        chk("swap_lat_3", W'(n), W'(1));

        // Flush while FULL discards the kernel; later swap_req is ignored.
        wgt_valid = 1'b1;
        wgt_in = DW'(1);
        repeat (N) step();
        wgt_valid = 1'b0;
        chk("full_1", W'(shadow_full), W'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_clr", W'(shadow_full), W'(0));
        chk("flush_ready", W'(wgt_ready), W'(1));
        chk("flush_act_keep", act_wgt, k_3);
        swap_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ignored_swap", W'(swap_ack), W'(0));
        end
        swap_req = 1'b0;
        chk("act_after_ignored", act_wgt, k_3);
        chk("act_valid_kept", W'(act_valid), W'(1));

        // Async reset mid-load.
        wgt_valid = 1'b1;
        wgt_in = DW'(4);
        repeat (5) step();
        #3 rst_n = 1'b0;
        #1;
        wgt_valid = 1'b0;
        chk("arst_ready", W'(wgt_ready), W'(1));
        chk("arst_full", W'(shadow_full), W'(0));
        chk("arst_ack", W'(swap_ack), W'(0));
        chk("arst_act_valid", W'(act_valid), W'(0));
        chk("arst_act_wgt", act_wgt, W'(0));
        step();
        rst_n = 1'b1;
        wgt_valid = 1'b1;
        wgt_in = DW'(2);
        for (int i = 0; i < N - 1; i++) begin
            step();
            chk("full_early_post_rst", W'(shadow_full), W'(0));
        end
        step();
        wgt_valid = 1'b0;
        chk("full_post_rst", W'(shadow_full), W'(1));
        chk("sb_drained", W'(sb_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
